comparator_iterative: RTL and testbench

- Multi-cycle operand comparator with valid/ready handshakes on both sides.
- Accepts a pair of N-bit operands plus a signed/unsigned select, and returns eq and lt flags.
- Examines CHUNK bits per cycle, starting at the MSB.
- Used where a single-cycle N-bit magnitude compare is too slow or too wide, e.g. a multi-cycle branch/slt unit or a self-check engine.

---
 rtl/comparator_pkg.sv | 18 +
 rtl/comparator_chunk.sv | 16 +
 rtl/comparator_iterative.sv | 118 +++++++++++
 tb/tb_comparator_iterative.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and defaults for the iterative operand comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_N     = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic bias_msb(input logic msb, input logic sgn);
    return msb ^ sgn;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational CHUNK-bit unsigned compare used once per BUSY cycle.
module comparator_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             chunk_eq,
  output logic             chunk_lt
);

  always_comb begin
    chunk_eq = (a == b);
    chunk_lt = (a < b);
  end

endmodule

// File: rtl/comparator_iterative.sv
// Multi-cycle eq/lt comparator, CHUNK bits per cycle from the MSB, valid/ready on both sides.
// Define COMPARATOR_EARLY_EXIT_EN to leave BUSY on the first mismatching chunk.
module comparator_iterative
  import comparator_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         eq,
  output logic         lt
);

  localparam int unsigned K  = N / CHUNK;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

`ifdef COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if ((N % CHUNK) != 0) begin : g_bad_cfg
    $error("comparator_iterative: N must be a multiple of CHUNK");
  end

  state_t          state;
  logic [N-1:0]    sa;
  logic [N-1:0]    sb;
  logic [CW-1:0]   count;
  logic            decided;
  logic            chunk_eq;
  logic            chunk_lt;
  logic            mismatch;
  logic            last_chunk;

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (sa[N-1 -: CHUNK]),
    .b        (sb[N-1 -: CHUNK]),
    .chunk_eq (chunk_eq),
    .chunk_lt (chunk_lt)
  );

  always_comb begin
    mismatch   = !decided && !chunk_eq;
    last_chunk = (count == CW'(K - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      count   <= '0;
      decided <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            sa      <= {bias_msb(a[N-1], is_signed), a[N-2:0]};
            sb      <= {bias_msb(b[N-1], is_signed), b[N-2:0]};
            count   <= '0;
            decided <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            o_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Only the first differing chunk may write lt; decided locks it.
          if (mismatch) begin
            decided <= 1'b1;
            eq      <= 1'b0;
            lt      <= chunk_lt;
          end
          if (last_chunk || (EARLY_EXIT && mismatch)) begin
            if (!decided && chunk_eq) begin
              eq <= 1'b1;
              lt <= 1'b0;
            end
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            sa    <= sa << CHUNK;
            sb    <= sb << CHUNK;
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_iterative.sv
// Directed and random self-checking bench for comparator_iterative (N=32, CHUNK=8).
module tb_comparator_iterative;

  localparam int unsigned N     = 32;
  localparam int unsigned CHUNK = 8;
  localparam int unsigned K     = N / CHUNK;

`ifdef COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          is_signed = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          o_ready;
  logic          o_valid;
  logic          eq;
  logic          lt;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int handoffs = 0;

  comparator_iterative #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .eq        (eq),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && i_valid && o_ready) accepts++;
    if (rst_n && o_valid && i_ready) handoffs++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [N-1:0] av, input logic [N-1:0] bv, input logic s);
    a = av;
    b = bv;
    is_signed = s;
    i_valid = 1'b1;
    chk("ready_before_accept", o_ready, 1);
    step();
    i_valid = 1'b0;
    chk("ready_low_after_accept", o_ready, 0);
    chk("eq_cleared_on_accept", eq, 0);
    chk("lt_cleared_on_accept", lt, 0);
  endtask

  // Counts cycles from the accept edge to o_valid; noisy mode scrambles inputs meanwhile.
  task automatic wait_valid(input bit noisy, output int lat);
    lat = 0;
    while (!o_valid && lat < 50) begin
      if (noisy) begin
        i_ready = 1'($urandom_range(0, 1));
        i_valid = 1'($urandom_range(0, 1));
        a = $urandom;
        b = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    i_valid = 1'b0;
    chk("valid_within_bound", o_valid, 1);
  endtask

  function automatic int exp_lat(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N-1:0] x;
    x = av ^ bv;
    if (!EARLY) return K;
    for (int i = 0; i < K; i++)
      if (x[N-1-i*CHUNK -: CHUNK] != '0) return i + 1;
    return K;
  endfunction

  initial begin
    int lat;
    int a0, h0;
    logic [N-1:0] ra, rb;
    logic rs, rlt, req;

    // Reset state
    step();
    step();
    chk("reset_o_ready", o_ready, 1);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_eq", eq, 0);
    chk("reset_lt", lt, 0);
    rst_n = 1'b1;
    step();

    // Equal operands: fixed K cycles, handoff, o_ready back one cycle later
    i_ready = 1'b1;
    start(32'd5, 32'd5, 1'b0);
    wait_valid(1'b0, lat);
    chk("eq5_latency", lat, K);
    chk("eq5_eq", eq, 1);
    chk("eq5_lt", lt, 0);
    chk("eq5_ready_in_done", o_ready, 0);
    step();
    chk("eq5_valid_dropped", o_valid, 0);
    chk("eq5_ready_back", o_ready, 1);

    // -1 vs 1, signed then unsigned
    start(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_valid(1'b0, lat);
    chk("m1_signed_latency", lat, exp_lat(32'hFFFF_FFFF, 32'h0000_0001));
    chk("m1_signed_lt", lt, 1);
    chk("m1_signed_eq", eq, 0);
    step();
    start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_valid(1'b0, lat);
    chk("m1_unsigned_lt", lt, 0);
    chk("m1_unsigned_eq", eq, 0);
    step();

    // Sign-boundary pair under both interpretations
    start(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    wait_valid(1'b0, lat);
    chk("minmax_signed_lt", lt, 1);
    chk("minmax_signed_eq", eq, 0);
    step();
    start(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_valid(1'b0, lat);
    chk("minmax_unsigned_lt", lt, 0);
    chk("minmax_unsigned_eq", eq, 0);
    step();

    // Last-chunk mismatch held under backpressure for 10 cycles
    i_ready = 1'b0;
    start(32'h1234_5600, 32'h1234_5601, 1'b0);
    wait_valid(1'b0, lat);
    chk("bp_latency", lat, K);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", o_valid, 1);
      chk("bp_eq_stable", eq, 0);
      chk("bp_lt_stable", lt, 1);
      step();
    end
    i_ready = 1'b1;
    step();
    chk("bp_handoff", o_valid, 0);
    chk("bp_ready_back", o_ready, 1);

    // Reset aborts an operation in flight
    start(32'd1, 32'd2, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_o_ready", o_ready, 1);
    chk("abort_o_valid", o_valid, 0);
    chk("abort_eq", eq, 0);
    chk("abort_lt", lt, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_valid", o_valid, 0);
      step();
    end
    start(32'd3, 32'd2, 1'b0);
    wait_valid(1'b0, lat);
    chk("post_abort_lt", lt, 0);
    chk("post_abort_eq", eq, 0);
    step();

    // First-chunk mismatch: latency 1 with early exit, K without
    start(32'h0100_0000, 32'h0200_0000, 1'b0);
    wait_valid(1'b0, lat);
    chk("early_latency", lat, EARLY ? 1 : K);
    chk("early_lt", lt, 1);
    chk("early_eq", eq, 0);
    step();

    // Random pairs with stalls and input noise during BUSY
    a0 = accepts;
    h0 = handoffs;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'hFF << (8 * $urandom_range(0, 3)));
        2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      rs  = 1'($urandom_range(0, 1));
      req = (ra == rb);
      rlt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
      start(ra, rb, rs);
      wait_valid(1'b1, lat);
      chk("rand_latency", lat, exp_lat(ra, rb));
      chk("rand_eq", eq, req);
      chk("rand_lt", lt, rlt);
      i_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("rand_stall_valid", o_valid, 1);
        chk("rand_stall_lt", lt, rlt);
      end
      i_ready = 1'b1;
      step();
      chk("rand_handoff", o_valid, 0);
    end
    chk("rand_accept_count", accepts - a0, 1000);
    chk("rand_handoff_count", handoffs - h0, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
